// File: rtl/popcount_pkg.sv
// Shared constants, FSM state encoding and summary metadata for the popcount
// frame accumulator.
package popcount_pkg;
  localparam int WORD_W  = 16;
  localparam int COUNT_W = 5;

  typedef enum logic [1:0] {IDLE, ACCUM, HOLD} state_t;

  // Width-independent part of a frame summary; sum/words widths follow MAX_WORDS.
  typedef struct packed {
    logic [COUNT_W-1:0] max;
    logic               overflow;
    logic               err;
  } summary_meta_t;

  function automatic logic [COUNT_W-1:0] clamp_count(input logic [COUNT_W-1:0] c);
    return (c > COUNT_W'(WORD_W)) ? COUNT_W'(WORD_W) : c;
  endfunction
endpackage

// File: rtl/popcount_frame_accumulator_if.sv
// Input count stream plus output frame-summary stream of the accumulator.
interface popcount_frame_accumulator_if #(
  parameter int SUM_W = 13,
  parameter int CNT_W = 9
);
  logic             in_valid;
  logic             in_ready;
  logic [4:0]       in_count;
  logic             in_last;
  logic             out_valid;
  logic             out_ready;
  logic [SUM_W-1:0] out_sum;
  logic [CNT_W-1:0] out_words;
  logic [4:0]       out_max;
  logic             out_overflow;
  logic             out_err;

  modport master (
    output in_valid, in_count, in_last, out_ready,
    input  in_ready, out_valid, out_sum, out_words, out_max, out_overflow, out_err
  );
  modport slave (
    input  in_valid, in_count, in_last, out_ready,
    output in_ready, out_valid, out_sum, out_words, out_max, out_overflow, out_err
  );
endinterface

// File: rtl/frame_summary_reg.sv
// Holding register for one frame summary; loads on close, releases on handshake.
module frame_summary_reg #(
  parameter type T = logic
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_load,
  input  T     i_data,
  input  logic i_ready,
  output logic o_valid,
  output T     o_data
);
  logic r_valid;
  T     r_data;

  // Load only happens outside HOLD, so it never races the release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid <= 1'b0;
      r_data  <= '0;
    end else if (i_load) begin
      r_valid <= 1'b1;
      r_data  <= i_data;
    end else if (r_valid && i_ready) begin
      r_valid <= 1'b0;
    end
  end

  assign o_valid = r_valid;
  assign o_data  = r_data;
endmodule

// File: rtl/popcount_frame_accumulator.sv
// Accumulates per-word ones counts into per-frame sum / word count / max and
// presents one registered summary per frame.
module popcount_frame_accumulator
  import popcount_pkg::*;
#(
  parameter int MAX_WORDS = 256,
  parameter int CNT_W     = $clog2(MAX_WORDS) + 1,
  parameter int SUM_W     = $clog2(MAX_WORDS * WORD_W) + 1
) (
  input logic clk,
  input logic rst_n,
  popcount_frame_accumulator_if.slave bus
);
  typedef struct packed {
    logic [SUM_W-1:0] sum;
    logic [CNT_W-1:0] words;
    summary_meta_t    meta;
  } summary_t;

  state_t             r_state, w_state_nxt;
  logic               r_in_ready;
  logic [SUM_W-1:0]   r_sum;
  logic [CNT_W-1:0]   r_words;
  logic [COUNT_W-1:0] r_max;
  logic               r_err;

  logic               w_acc, w_first, w_bad, w_close, w_hs, w_out_valid;
  logic [COUNT_W-1:0] w_cnt, w_max_nxt;
  logic [SUM_W-1:0]   w_sum_nxt;
  logic [CNT_W-1:0]   w_words_nxt;
  logic               w_err_nxt;
  summary_t           w_summary, w_out;

  assign w_acc       = bus.in_valid && r_in_ready;
  assign w_first     = (r_state == IDLE);
  assign w_cnt       = clamp_count(bus.in_count);
  assign w_bad       = bus.in_count > COUNT_W'(WORD_W);
  assign w_sum_nxt   = (w_first ? '0 : r_sum) + SUM_W'(w_cnt);
  assign w_words_nxt = (w_first ? '0 : r_words) + CNT_W'(1);
  assign w_max_nxt   = (w_first || (w_cnt > r_max)) ? w_cnt : r_max;
  assign w_err_nxt   = (!w_first && r_err) || w_bad;
  assign w_close     = w_acc && (bus.in_last || (w_words_nxt == CNT_W'(MAX_WORDS)));
  assign w_hs        = w_out_valid && bus.out_ready;

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      IDLE:    if (w_acc) w_state_nxt = w_close ? HOLD : ACCUM;
      ACCUM:   if (w_close) w_state_nxt = HOLD;
      HOLD:    if (w_hs) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // in_ready is registered so it stays low through reset and rises only the
  // cycle after a HOLD release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_in_ready <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_in_ready <= (w_state_nxt != HOLD);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sum   <= '0;
      r_words <= '0;
      r_max   <= '0;
      r_err   <= 1'b0;
    end else if (w_acc) begin
      r_sum   <= w_sum_nxt;
      r_words <= w_words_nxt;
      r_max   <= w_max_nxt;
      r_err   <= w_err_nxt;
    end
  end

  assign w_summary = '{sum:   w_sum_nxt,
                       words: w_words_nxt,
                       meta:  '{max: w_max_nxt, overflow: !bus.in_last, err: w_err_nxt}};

  frame_summary_reg #(.T(summary_t)) u_summary (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_load (w_close),
    .i_data (w_summary),
    .i_ready(bus.out_ready),
    .o_valid(w_out_valid),
    .o_data (w_out)
  );

  assign bus.in_ready     = r_in_ready;
  assign bus.out_valid    = w_out_valid;
  assign bus.out_sum      = w_out.sum;
  assign bus.out_words    = w_out.words;
  assign bus.out_max      = w_out.meta.max;
  assign bus.out_overflow = w_out.meta.overflow;
  assign bus.out_err      = w_out.meta.err;
endmodule
